// File: rtl/modulo_condicionador_confirmacao.sv
// Confirmation pushbutton conditioner for the game datapath.
// Raw active-low button -> 2-flop synchronizer -> debouncer -> one-shot on
// press, then each accepted press is steered by the mode switches into a
// one-hot single-cycle strobe. A small game-phase FSM plus a shot budget
// decide which strobes are allowed through.
module modulo_condicionador_confirmacao #(
    parameter int DEB_CYCLES = 500000,
    parameter int MAX_SHOTS  = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       button_n,
    input  logic [1:0] mode,
    output logic [3:0] strobe,
    output logic [1:0] phase,
    output logic [5:0] shots_left,
    output logic       game_over
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [5:0] SHOTS_MAX = 6'(MAX_SHOTS);

    localparam logic [1:0] PH_SETUP = 2'b00;
    localparam logic [1:0] PH_PLAY  = 2'b01;
    localparam logic [1:0] PH_OVER  = 2'b10;

    localparam logic [1:0] MODE_CLEAR    = 2'b00;
    localparam logic [1:0] MODE_ATTACK   = 2'b01;
    localparam logic [1:0] MODE_POSITION = 2'b10;
    localparam logic [1:0] MODE_SPARE    = 2'b11;

    // ------------------------------------------------------------------
    // Synchronizer: two flops, reset to the released level (1).
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous button.
                always_ff @(posedge clk) begin
                    if (clr) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= button_n;
                end
            end else begin : g_rest
                // Later stages only shift the previous stage.
                always_ff @(posedge clk) begin
                    if (clr) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    logic sync;
    assign sync = sync_reg[1];

    // ------------------------------------------------------------------
    // Debouncer: the level is only accepted after DEB_CYCLES consecutive
    // edges disagreeing with the current debounced value.
    // ------------------------------------------------------------------
    logic             deb_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             mismatch;
    logic             accept;
    logic             fall_now;

    assign mismatch = (sync != deb_reg);
    assign accept   = mismatch && (cnt_reg == CNT_LAST);
    // A press is the debounced level going 1 -> 0; release emits nothing.
    assign fall_now = accept && deb_reg;

    // Counter and debounced level update.
    always_ff @(posedge clk) begin
        if (clr) begin
            deb_reg <= 1'b1;
            cnt_reg <= '0;
        end else if (accept) begin
            deb_reg <= sync;
            cnt_reg <= '0;
        end else if (mismatch) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end else begin
            cnt_reg <= '0;
        end
    end

    // ------------------------------------------------------------------
    // One-shot: mode is captured at the edge where the debounced level
    // falls; the strobe decision is made on the following edge, so later
    // mode changes while the button is held have no effect.
    // ------------------------------------------------------------------
    logic       press_reg;
    logic [1:0] mode_reg;

    // Capture the press event and the mode that goes with it.
    always_ff @(posedge clk) begin
        if (clr) begin
            press_reg <= 1'b0;
            mode_reg  <= MODE_CLEAR;
        end else begin
            press_reg <= fall_now;
            if (fall_now) mode_reg <= mode;
        end
    end

    // One-hot decode of the captured mode.
    logic [3:0] mode_onehot;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign mode_onehot[gi] = (mode_reg == 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Gating FSM and shot budget.
    // ------------------------------------------------------------------
    logic [1:0] phase_reg;
    logic [1:0] phase_next;
    logic [5:0] shots_reg;
    logic [5:0] shots_next;
    logic [3:0] strobe_reg;
    logic [3:0] strobe_next;
    logic       allow;

    // Decide whether the pending press passes and what state it leaves.
    always_comb begin
        allow      = 1'b0;
        phase_next = phase_reg;
        shots_next = shots_reg;
        if (press_reg) begin
            case (phase_reg)
                PH_SETUP: begin
                    case (mode_reg)
                        MODE_CLEAR:    allow = 1'b1;
                        MODE_POSITION: allow = 1'b1;
                        MODE_SPARE:    allow = 1'b1;
                        MODE_ATTACK: begin
                            // Budget guard keeps shots_left from wrapping.
                            if (shots_reg != 6'd0) begin
                                allow      = 1'b1;
                                shots_next = shots_reg - 6'd1;
                                phase_next = (shots_reg == 6'd1) ? PH_OVER : PH_PLAY;
                            end
                        end
                        default: allow = 1'b0;
                    endcase
                end
                PH_PLAY: begin
                    case (mode_reg)
                        MODE_CLEAR: begin
                            allow      = 1'b1;
                            shots_next = SHOTS_MAX;
                            phase_next = PH_SETUP;
                        end
                        MODE_ATTACK: begin
                            if (shots_reg != 6'd0) begin
                                allow      = 1'b1;
                                shots_next = shots_reg - 6'd1;
                                if (shots_reg == 6'd1) phase_next = PH_OVER;
                            end
                        end
                        MODE_SPARE:    allow = 1'b1;
                        MODE_POSITION: allow = 1'b0;
                        default:       allow = 1'b0;
                    endcase
                end
                default: begin
                    // OVER (and the unused encoding): only a clear restarts.
                    if (mode_reg == MODE_CLEAR) begin
                        allow      = 1'b1;
                        shots_next = SHOTS_MAX;
                        phase_next = PH_SETUP;
                    end
                end
            endcase
        end
        strobe_next = allow ? mode_onehot : 4'b0000;
    end

    // Register strobe, phase and budget together on the decision edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            strobe_reg <= 4'b0000;
            phase_reg  <= PH_SETUP;
            shots_reg  <= SHOTS_MAX;
        end else begin
            strobe_reg <= strobe_next;
            phase_reg  <= phase_next;
            shots_reg  <= shots_next;
        end
    end

    assign strobe     = strobe_reg;
    assign phase      = phase_reg;
    assign shots_left = shots_reg;
    assign game_over  = (phase_reg == PH_OVER);

endmodule

// File: tb/tb_modulo_condicionador_confirmacao.sv
// Directed bench for the confirmation conditioner (DEB_CYCLES=4, MAX_SHOTS=3).
module tb_modulo_condicionador_confirmacao;

    logic       clk = 1'b0;
    logic       clr;
    logic       button_n;
    logic [1:0] mode;
    logic [3:0] strobe;
    logic [1:0] phase;
    logic [5:0] shots_left;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    modulo_condicionador_confirmacao #(
        .DEB_CYCLES(4),
        .MAX_SHOTS (3)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .button_n  (button_n),
        .mode      (mode),
        .strobe    (strobe),
        .phase     (phase),
        .shots_left(shots_left),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] m;
        logic [3:0] s;
        logic [1:0] p;
        int         sh;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] p, input int sh);
        check({tag, " phase"}, int'(phase), int'(p));
        check({tag, " shots_left"}, int'(shots_left), sh);
        check({tag, " game_over"}, int'(game_over), (p == 2'b10) ? 1 : 0);
    endtask

    // Press with the given mode, hold, release; edge k is the first posedge
    // after button_n falls, the strobe is expected in the sample after edge k+6.
    task automatic do_press(input int n, input logic [1:0] m, input logic [3:0] exp_s,
                            input logic [1:0] exp_p, input int exp_sh);
        int         cnt;
        int         idx;
        logic [3:0] val;
        string      tag;
        tag = $sformatf("press%0d", n);
        @(negedge clk);
        mode     = m;
        button_n = 1'b0;
        cnt = 0;
        idx = -1;
        val = 4'b0000;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (strobe != 4'b0000) begin
                cnt++;
                if (idx < 0) begin
                    idx = i;
                    val = strobe;
                end
            end
            if (i == 5) mode = ~m;
            if (i == 20) button_n = 1'b1;
        end
        if (exp_s != 4'b0000) begin
            check({tag, " pulse_count"}, cnt, 1);
            check({tag, " pulse_time"}, idx, 6);
            check({tag, " strobe"}, int'(val), int'(exp_s));
        end else begin
            check({tag, " pulse_count"}, cnt, 0);
        end
        check_state(tag, exp_p, exp_sh);
        $display("%s mode=%b strobe=%b at=%0d pulses=%0d phase=%b shots=%0d", tag, m, val,
                 idx, cnt, phase, shots_left);
    endtask

    initial begin
        int         cnt;
        int         idx;
        logic [3:0] val;
        int         bad_s;
        int         bad_d;

        tbl[0]  = '{2'b10, 4'b0100, 2'b00, 3};
        tbl[1]  = '{2'b01, 4'b0010, 2'b01, 2};
        tbl[2]  = '{2'b01, 4'b0010, 2'b01, 1};
        tbl[3]  = '{2'b01, 4'b0010, 2'b10, 0};
        tbl[4]  = '{2'b01, 4'b0000, 2'b10, 0};
        tbl[5]  = '{2'b10, 4'b0000, 2'b10, 0};
        tbl[6]  = '{2'b00, 4'b0001, 2'b00, 3};
        tbl[7]  = '{2'b11, 4'b1000, 2'b00, 3};
        tbl[8]  = '{2'b00, 4'b0001, 2'b00, 3};
        tbl[9]  = '{2'b01, 4'b0010, 2'b01, 2};
        tbl[10] = '{2'b10, 4'b0000, 2'b01, 2};
        tbl[11] = '{2'b11, 4'b1000, 2'b01, 2};
        tbl[12] = '{2'b00, 4'b0001, 2'b00, 3};
        tbl[13] = '{2'b01, 4'b0010, 2'b01, 2};

        // Reset.
        clr      = 1'b1;
        button_n = 1'b1;
        mode     = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset strobe", int'(strobe), 0);
        check_state("reset", 2'b00, 3);
        $display("reset strobe=%b phase=%b shots=%0d game_over=%b", strobe, phase, shots_left,
                 game_over);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);

        // Table of presses.
        for (int t = 0; t < 14; t++) begin
            do_press(t, tbl[t].m, tbl[t].s, tbl[t].p, tbl[t].sh);
        end

        // Glitch rejection: low pulses of 1, 2 and 3 cycles.
        bad_s = 0;
        bad_d = 0;
        for (int len = 1; len <= 3; len++) begin
            for (int c = 0; c < len + 8; c++) begin
                @(negedge clk);
                button_n = (c < len) ? 1'b0 : 1'b1;
                if (strobe != 4'b0000) bad_s++;
                if (dut.deb_reg !== 1'b1) bad_d++;
            end
        end
        check("glitch strobes", bad_s, 0);
        check("glitch deb_low", bad_d, 0);
        check_state("glitch", 2'b01, 2);
        $display("glitch strobe_cycles=%0d deb_low_cycles=%0d", bad_s, bad_d);

        // Reset mid-debounce: clr high at edges k+2 and k+3, button held.
        @(negedge clk);
        mode     = 2'b10;
        button_n = 1'b0;
        cnt = 0;
        idx = -1;
        val = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (strobe != 4'b0000) begin
                cnt++;
                if (idx < 0) begin
                    idx = i;
                    val = strobe;
                end
            end
            if (i == 1) clr = 1'b1;
            if (i == 3) begin
                check("midrst strobe", int'(strobe), 0);
                check_state("midrst during", 2'b00, 3);
                clr = 1'b0;
            end
            if (i == 22) button_n = 1'b1;
        end
        check("midrst pulse_count", cnt, 1);
        check("midrst pulse_time", idx, 10);
        check("midrst strobe_val", int'(val), 4);
        check_state("midrst after", 2'b00, 3);
        $display("midrst strobe=%b at=%0d pulses=%0d phase=%b shots=%0d", val, idx, cnt, phase,
                 shots_left);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
